// File: rtl/hdb3_pkg.sv
// hdb3_pkg: symbol codes and coding-rule limits shared by the HDB3 encoder stages
package hdb3_pkg;
  localparam logic [1:0] HDB3_0 = 2'b00;
  localparam logic [1:0] HDB3_1 = 2'b01;
  localparam logic [1:0] HDB3_V = 2'b11;
  localparam logic [1:0] HDB3_B = 2'b10;
  localparam int unsigned HDB3_MAX_ZEROS = 3;
  function automatic logic is_mark(input logic [1:0] code);
    return code != HDB3_0;
  endfunction
endpackage

// File: rtl/hdb3_rule_check.sv
// hdb3_rule_check: zero-run and V-alternation monitors, flags aligned with the emitted symbol
module hdb3_rule_check
  import hdb3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] code,
  input  logic       pol,
  output logic       err_zero_run,
  output logic       err_v_alt
);
  logic [2:0] zrun;
  logic       last_v_pol;
  logic       v_seen;
  logic       is_zero;
  logic       is_v;
  assign is_zero = !is_mark(code);
  assign is_v    = code == HDB3_V;
  always_ff @(posedge clk) begin
    if (rst) begin
      zrun         <= '0;
      last_v_pol   <= 1'b0;
      v_seen       <= 1'b0;
      err_zero_run <= 1'b0;
      err_v_alt    <= 1'b0;
    end else begin
      // counter saturates one past the limit so every further zero keeps flagging
      zrun         <= is_zero ? ((zrun > 3'(HDB3_MAX_ZEROS)) ? zrun : zrun + 3'd1) : 3'd0;
      err_zero_run <= is_zero && (zrun >= 3'(HDB3_MAX_ZEROS));
      err_v_alt    <= is_v && v_seen && (pol == last_v_pol);
      if (is_v) begin
        last_v_pol <= pol;
        v_seen     <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/hdb3_polarity.sv
// hdb3_polarity: assigns line polarity to HDB3 symbols and drives the bipolar rail pair
module hdb3_polarity
  import hdb3_pkg::*;
#(
  parameter bit INIT_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] code_in,
  output logic       hdb3_p,
  output logic       hdb3_n,
  output logic       err_zero_run,
  output logic       err_v_alt
);
  logic last_pol;
  logic pol;
  logic mark;
  // V deliberately repeats the previous pulse polarity; 1 and B alternate it
  assign pol  = (code_in == HDB3_V) ? last_pol : ~last_pol;
  assign mark = is_mark(code_in);
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pol <= INIT_POL;
      hdb3_p   <= 1'b0;
      hdb3_n   <= 1'b0;
    end else begin
      last_pol <= mark ? pol : last_pol;
      hdb3_p   <= mark & pol;
      hdb3_n   <= mark & ~pol;
    end
  end
  hdb3_rule_check u_rule_check (
    .clk          (clk),
    .rst          (rst),
    .code         (code_in),
    .pol          (pol),
    .err_zero_run (err_zero_run),
    .err_v_alt    (err_v_alt)
  );
endmodule
